// File: rtl/definitions.sv
// Shared CPU/AXI definitions: memory access sizes and single-beat AXI burst constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package definitions;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam axi_burst_t AXI_BURST_INCR = BURST_INCR;

endpackage

// File: rtl/axi_single_writer.sv
// Single-beat AXI write engine: AW and W issued independently, then waits for B.
// Latency: AW/W valid the cycle after start; bdone is combinational with the B handshake.
// Backpressure: each valid holds until its own ready; bready only after both AW and W completed.
module axi_single_writer
    import definitions::*;
#(
    parameter int ID_W  = 4,
    parameter int WR_ID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [31:0]     addr,
    input  mem_size_t       size,
    input  logic [3:0]      wstrb,
    input  logic [31:0]     wdata,
    output logic            busy,
    output logic            bdone,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     awaddr,
    output logic [2:0]      awsize,
    output logic [ID_W-1:0] awid,
    output logic            wvalid,
    input  logic            wready,
    output logic [31:0]     axi_wdata,
    output logic [3:0]      axi_wstrb,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [1:0] {W_IDLE, WR_AW, WR_B} wstate_t;

    wstate_t     state, state_nx;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    mem_size_t   size_q;

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign busy      = (state != W_IDLE);
    assign awaddr    = addr_q;
    assign awsize    = {1'b0, size_q};
    assign awid      = ID_W'(WR_ID);
    assign axi_wdata = wdata_q;
    assign axi_wstrb = wstrb_q;

    // State register plus per-channel completion flags, cleared when a new write starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end

    // Capture the store so the front end is free to take another request.
    always_ff @(posedge clk) begin
        if (start) begin
            addr_q  <= addr;
            size_q  <= size;
            wstrb_q <= wstrb;
            wdata_q <= wdata;
        end
    end

    // Next state and channel valids; AW and W complete in any order, B waits for both.
    always_comb begin
        state_nx = state;
        bdone    = 1'b0;
        awvalid  = (state == WR_AW) && !aw_done;
        wvalid   = (state == WR_AW) && !w_done;
        bready   = (state == WR_B);
        case (state)
            W_IDLE: if (start) state_nx = WR_AW;
            WR_AW:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WR_B;
            WR_B: begin
                if (bvalid) begin
                    state_nx = W_IDLE;
                    bdone    = 1'b1;
                end
            end
            default: state_nx = W_IDLE;
        endcase
    end

endmodule

// File: rtl/data_sram_axi_bridge.sv
// CPU data-port req/addr_ok/data_ok responder performing one single-beat AXI4 read or write at a time.
// Latency: load data_ok >= 3 cycles after acceptance; store data_ok one cycle after B (or after acceptance with DATA_BRIDGE_POSTED_WRITE_EN).
// Backpressure: addr_ok low while busy; AXI valids hold until ready. Macro DATA_BRIDGE_POSTED_WRITE_EN enables posted stores.
module data_sram_axi_bridge
    import definitions::*;
#(
    parameter int ID_W  = 4,
    parameter int RD_ID = 1,
    parameter int WR_ID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            wr,
    input  mem_size_t       size,
    input  logic [31:0]     addr,
    input  logic [3:0]      wstrb,
    input  logic [31:0]     wdata,
    output logic            addr_ok,
    output logic            data_ok,
    output logic [31:0]     rdata,
    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [2:0]      arsize,
    output logic [ID_W-1:0] arid,
    input  logic            rvalid,
    output logic            rready,
    input  logic [31:0]     axi_rdata,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     awaddr,
    output logic [2:0]      awsize,
    output logic [ID_W-1:0] awid,
    output logic            wvalid,
    input  logic            wready,
    output logic [31:0]     axi_wdata,
    output logic [3:0]      axi_wstrb,
    output logic            wlast,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [1:0] {IDLE, RD_A, RD_D, WR_WAIT} state_t;

    state_t      state, state_nx;
    logic        accept, wr_start, wr_busy, wr_bdone, wbuf_free, data_ok_nx;
    logic [31:0] rd_addr_q;
    mem_size_t   rd_size_q;

`ifdef DATA_BRIDGE_POSTED_WRITE_EN
    // Stores wait for the previous B; loads are taken but held off AR until it returns.
    assign wbuf_free = !(wr && wr_busy);
    assign arvalid   = (state == RD_A) && !wr_busy;
`else
    assign wbuf_free = !wr_busy;
    assign arvalid   = (state == RD_A);
`endif

    assign addr_ok  = req && (state == IDLE) && wbuf_free;
    assign accept   = req && addr_ok;
    assign wr_start = accept && wr;
    assign rready   = (state == RD_D);
    assign araddr   = rd_addr_q;
    assign arsize   = {1'b0, rd_size_q};
    assign arid     = ID_W'(RD_ID);
    assign wlast    = 1'b1;

    // Front FSM state, completion pulse and load data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            data_ok <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            state   <= state_nx;
            data_ok <= data_ok_nx;
            if ((state == RD_D) && rvalid) rdata <= axi_rdata;
        end
    end

    // Load address/size held for the AR channel while the read is in flight.
    always_ff @(posedge clk) begin
        if (accept && !wr) begin
            rd_addr_q <= addr;
            rd_size_q <= size;
        end
    end

    // Next state and the registered data_ok request.
    always_comb begin
        state_nx   = state;
        data_ok_nx = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!wr) begin
                        state_nx = RD_A;
                    end else begin
`ifdef DATA_BRIDGE_POSTED_WRITE_EN
                        data_ok_nx = 1'b1;
`else
                        state_nx = WR_WAIT;
`endif
                    end
                end
            end
            RD_A: if (arvalid && arready) state_nx = RD_D;
            RD_D: begin
                if (rvalid) begin
                    state_nx   = IDLE;
                    data_ok_nx = 1'b1;
                end
            end
            WR_WAIT: begin
                if (wr_bdone) begin
                    state_nx   = IDLE;
                    data_ok_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    axi_single_writer #(
        .ID_W  (ID_W),
        .WR_ID (WR_ID)
    ) u_writer (
        .clk       (clk),
        .reset     (reset),
        .start     (wr_start),
        .addr      (addr),
        .size      (size),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .busy      (wr_busy),
        .bdone     (wr_bdone),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awsize    (awsize),
        .awid      (awid),
        .wvalid    (wvalid),
        .wready    (wready),
        .axi_wdata (axi_wdata),
        .axi_wstrb (axi_wstrb),
        .bvalid    (bvalid),
        .bready    (bready)
    );

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge: table of single transactions plus multi-cycle corner sequences.
// Latency: checks exact data_ok cycle relative to acceptance.
// Backpressure: per-channel ready/response delays come from the vector table.
module tb_data_sram_axi_bridge;
    import definitions::*;

    localparam int ID_W = 4;

    logic            clk, reset, req, wr;
    mem_size_t       size;
    logic [31:0]     addr, wdata, rdata, araddr, axi_rdata, awaddr, axi_wdata;
    logic [3:0]      wstrb, axi_wstrb;
    logic            addr_ok, data_ok, arvalid, arready, rvalid, rready;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [2:0]      arsize, awsize;
    logic [ID_W-1:0] arid, awid;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_rd = 32'h0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        mem_size_t   size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
        logic [2:0]  exp_axsize;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    data_sram_axi_bridge #(.ID_W(ID_W), .RD_ID(1), .WR_ID(1)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize), .arid(arid),
        .rvalid(rvalid), .rready(rready), .axi_rdata(axi_rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize), .awid(awid),
        .wvalid(wvalid), .wready(wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_axi();
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; axi_rdata = 32'h0;
    endtask

    // One request through a responder whose ready/response delays come from the vector.
    task automatic run_txn(input string nm, input vec_t v);
        int lat, dok, ar_n, r_n, aw_n, w_n, b_n, ar_hs, r_hs, aw_hs, w_hs, b_hs, unstable, early_b, elat;
        logic ar_pend, aw_pend, w_pend, done, cap_last;
        logic [31:0] ar_hold, aw_hold, cap_addr, cap_wd, cap_rd;
        logic [35:0] w_hold;
        logic [3:0]  cap_st;
        logic [2:0]  cap_size;
        logic [ID_W-1:0] cap_id;
        lat = 0; dok = 0; ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; unstable = 0; early_b = 0;
        ar_pend = 0; aw_pend = 0; w_pend = 0; done = 0; cap_last = 0;
        ar_hold = 0; aw_hold = 0; w_hold = 0; cap_addr = 0; cap_wd = 0; cap_rd = 0;
        cap_st = 0; cap_size = 0; cap_id = 0;
        req = 1; wr = v.wr; addr = v.addr; size = v.size; wstrb = v.wstrb; wdata = v.wdata;
        #1 check({nm, "_accept"}, addr_ok, 1);
        @(negedge clk);
        req = 0;
        for (int c = 1; c <= 80 && !done; c++) begin
            arready   = arvalid && (ar_n >= v.ar_dly);
            awready   = awvalid && (aw_n >= v.aw_dly);
            wready    = wvalid && (w_n >= v.w_dly);
            rvalid    = rready && (r_n >= v.r_dly);
            bvalid    = bready && (b_n >= v.b_dly);
            axi_rdata = rvalid ? v.rdata : 32'h0;
            #1;
            if (data_ok) begin
                dok++;
                if (lat == 0) begin lat = c; cap_rd = rdata; end
            end
            if (ar_pend && (!arvalid || araddr != ar_hold)) unstable++;
            if (aw_pend && (!awvalid || awaddr != aw_hold)) unstable++;
            if (w_pend && (!wvalid || {axi_wstrb, axi_wdata} != w_hold)) unstable++;
            if (bready && (aw_hs == 0 || w_hs == 0)) early_b++;
            if (arvalid && arready) begin ar_hs++; cap_addr = araddr; cap_size = arsize; cap_id = arid; end
            if (awvalid && awready) begin aw_hs++; cap_addr = awaddr; cap_size = awsize; cap_id = awid; end
            if (wvalid && wready) begin w_hs++; cap_wd = axi_wdata; cap_st = axi_wstrb; cap_last = wlast; end
            if (rvalid && rready) r_hs++;
            if (bvalid && bready) b_hs++;
            ar_pend = arvalid && !arready; ar_hold = araddr;
            aw_pend = awvalid && !awready; aw_hold = awaddr;
            w_pend  = wvalid && !wready;   w_hold  = {axi_wstrb, axi_wdata};
            if (arvalid) ar_n++;
            if (awvalid) aw_n++;
            if (wvalid)  w_n++;
            if (rready)  r_n++;
            if (bready)  b_n++;
            done = (dok > 0) && (v.wr ? (b_hs > 0) : (r_hs > 0));
            @(negedge clk);
        end
        clear_axi();
        #1 if (data_ok) dok++;
        if (!done) check({nm, "_timeout"}, 0, 1);
        elat = v.exp_lat;
`ifdef DATA_BRIDGE_POSTED_WRITE_EN
        if (v.wr) elat = 1;
`endif
        check({nm, "_latency"}, lat, elat);
        check({nm, "_pulses"}, dok, 1);
        check({nm, "_unstable"}, unstable, 0);
        check({nm, "_axaddr"}, cap_addr, v.addr);
        check({nm, "_axsize"}, cap_size, v.exp_axsize);
        check({nm, "_axid"}, cap_id, 1);
        if (v.wr) begin
            check({nm, "_wdata"}, cap_wd, v.wdata);
            check({nm, "_wstrb"}, cap_st, v.wstrb);
            check({nm, "_wlast"}, cap_last, 1);
            check({nm, "_hs_count"}, {ar_hs[7:0], aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 32'h00010101);
            check({nm, "_early_bready"}, early_b, 0);
            check({nm, "_rdata_hold"}, rdata, last_rd);
        end else begin
            check({nm, "_hs_count"}, {ar_hs[7:0], r_hs[7:0], aw_hs[7:0], w_hs[7:0]}, 32'h01010000);
            check({nm, "_rdata"}, cap_rd, v.rdata);
            last_rd = v.rdata;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar_bad, aok_bad, dok_cnt, arv_bad;
        //          wr    addr          size      strb     wdata          rdata         ar r  aw w  b  axsize  lat
        vecs[0] = '{1'b0, 32'h1c000004, MEM_WORD, 4'h0,    32'h0,         32'hdeadbeef, 0, 1, 0, 0, 0, 3'b010, 4};
        vecs[1] = '{1'b0, 32'h00000010, MEM_WORD, 4'h0,    32'h0,         32'h12345678, 0, 0, 0, 0, 0, 3'b010, 3};
        vecs[2] = '{1'b1, 32'h1c000003, MEM_BYTE, 4'b1000, 32'h55000000,  32'h0,        0, 0, 2, 0, 0, 3'b000, 5};
        vecs[3] = '{1'b1, 32'h80001002, MEM_HALF, 4'b1100, 32'habcd0000,  32'h0,        0, 0, 0, 3, 2, 3'b001, 8};
        vecs[4] = '{1'b1, 32'h00000100, MEM_WORD, 4'b1111, 32'hcafef00d,  32'h0,        0, 0, 1, 1, 0, 3'b010, 4};
        vecs[5] = '{1'b0, 32'h20000006, MEM_HALF, 4'h0,    32'h0,         32'h5a5a0000, 4, 2, 0, 0, 0, 3'b001, 9};
        vecs[6] = '{1'b0, 32'h00000003, MEM_BYTE, 4'h0,    32'h0,         32'h000000ff, 10, 0, 0, 0, 0, 3'b000, 13};

        reset = 1; req = 0; wr = 0; size = MEM_WORD; addr = 0; wstrb = 0; wdata = 0;
        clear_axi();
        repeat (3) @(negedge clk);
        reset = 0;

        // Reset state.
        #1;
        check("rst_data_ok", data_ok, 0);
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        check("rst_rdata", rdata, 0);
        req = 1;
        #1 check("rst_addr_ok", addr_ok, 1);
        req = 0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // arready stalled 10 cycles with a store waiting behind, then back-to-back acceptance.
        ar_bad = 0; aok_bad = 0; dok_cnt = 0;
        req = 1; wr = 0; addr = 32'h1c000040; size = MEM_WORD;
        #1 check("b2b_accept_ld", addr_ok, 1);
        @(negedge clk);
        wr = 1; addr = 32'h1c000044; size = MEM_WORD; wstrb = 4'hf; wdata = 32'h0badcafe;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!arvalid || araddr != 32'h1c000040) ar_bad++;
            if (addr_ok) aok_bad++;
            dok_cnt += int'(data_ok);
            @(negedge clk);
        end
        check("stall_ar_stable", ar_bad, 0);
        check("stall_addr_ok_low", aok_bad, 0);
        arready = 1;
        #1 check("stall_arvalid_at_hs", arvalid, 1);
        dok_cnt += int'(data_ok);
        @(negedge clk);
        arready = 0; rvalid = 1; axi_rdata = 32'h13579bdf;
        #1 check("b2b_rready", {rready, addr_ok}, 2'b10);
        dok_cnt += int'(data_ok);
        @(negedge clk);
        rvalid = 0;
        #1 check("b2b_dok_with_addr_ok", {data_ok, addr_ok}, 2'b11);
        check("b2b_rdata", rdata, 32'h13579bdf);
        last_rd = 32'h13579bdf;
        dok_cnt += int'(data_ok);
        @(negedge clk);
        req = 0; awready = 1; wready = 1;
        #1 check("b2b_aw_w_valid", {awvalid, wvalid}, 2'b11);
        check("b2b_awaddr", awaddr, 32'h1c000044);
        dok_cnt += int'(data_ok);
        @(negedge clk);
        awready = 0; wready = 0; bvalid = 1;
        #1 check("b2b_bready", bready, 1);
        dok_cnt += int'(data_ok);
        @(negedge clk);
        bvalid = 0;
        #1 dok_cnt += int'(data_ok);
        @(negedge clk);
        #1 dok_cnt += int'(data_ok);
        check("b2b_two_pulses", dok_cnt, 2);
        @(negedge clk);

        // Reset while waiting for R.
        req = 1; wr = 0; addr = 32'h1c000080; size = MEM_WORD;
        #1 check("rstmid_accept", addr_ok, 1);
        @(negedge clk);
        req = 0; arready = 1;
        @(negedge clk);
        arready = 0;
        #1 check("rstmid_in_rd_d", rready, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1 check("rstmid_after", {rready, data_ok, arvalid}, 0);
        check("rstmid_rdata", rdata, 0);
        last_rd = 32'h0;
        run_txn("rstmid_next", vecs[1]);

`ifdef DATA_BRIDGE_POSTED_WRITE_EN
        // Posted store then load to the same address; AR must wait for B.
        arv_bad = 0;
        req = 1; wr = 1; addr = 32'h1c000100; size = MEM_WORD; wstrb = 4'hf; wdata = 32'h600df00d;
        #1 check("post_accept_st", addr_ok, 1);
        @(negedge clk);
        wr = 0; awready = 1; wready = 1;
        #1 check("post_dok_early", data_ok, 1);
        check("post_accept_ld", addr_ok, 1);
        if (arvalid) arv_bad++;
        @(negedge clk);
        req = 0; awready = 0; wready = 0;
        for (int i = 0; i < 5; i++) begin
            #1 if (arvalid) arv_bad++;
            @(negedge clk);
        end
        bvalid = 1;
        #1 if (arvalid) arv_bad++;
        check("post_bready", bready, 1);
        @(negedge clk);
        bvalid = 0;
        check("post_ar_held", arv_bad, 0);
        #1 check("post_ar_after_b", arvalid, 1);
        check("post_araddr", araddr, 32'h1c000100);
        arready = 1;
        @(negedge clk);
        arready = 0; rvalid = 1; axi_rdata = 32'h600df00d;
        @(negedge clk);
        rvalid = 0;
        #1 check("post_load_done", {data_ok, rdata}, {1'b1, 32'h600df00d});
        @(negedge clk);
`else
        arv_bad = 0;
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
